// File: rtl/mem_ctrl_v2.sv
// mem_ctrl_v2: parametrised single-port scratch RAM slave with a
// valid/ready request channel and a valid/ready response channel.
// After reset a sweep clears every word before requests are accepted.
// One transaction is outstanding at a time. The response appears
// RD_LATENCY cycles after the request is accepted.
// Optional build macro MEM_BYTE_STROBE_EN enables per-byte write strobes.
// Without it, wstrb_i is ignored and every write updates the full word.
module mem_ctrl_v2 #(
  parameter int WIDTH      = 16,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic                  wr_rd_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WIDTH-1:0]      wdata_i,
  input  logic [WIDTH/8-1:0]    wstrb_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [WIDTH-1:0]      rdata_o,
  output logic                  err_o
);

  localparam int                  NBYTES    = WIDTH / 8;
  localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [1:0]          LAT_LAST  = 2'((RD_LATENCY > 1) ? (RD_LATENCY - 2) : 0);

  typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] sweep_q;
  logic [1:0]            lat_q;
  logic                  ready_q;
  logic                  resp_valid_q;
  logic [WIDTH-1:0]      rdata_q;
  logic                  err_q;
  logic [WIDTH-1:0]      mem_q [0:DEPTH-1];

  logic                  accept;
  logic                  addr_err;
  logic                  wr_en;
  logic [WIDTH-1:0]      rdata_d;

  // Request decode: accept only in IDLE (ready_q is high only there).
  assign accept   = valid_i & ready_q;
  assign addr_err = ({1'b0, addr_i} >= DEPTH_C);
  assign wr_en    = accept & wr_rd_i & ~addr_err;

  // Read data captured at accept; writes and errors answer with zero.
  always_comb begin
    rdata_d = '0;
    if (!wr_rd_i && !addr_err) begin
      rdata_d = mem_q[addr_i];
    end
  end

`ifdef MEM_BYTE_STROBE_EN
  // Storage array: init sweep writes full words, requests honour strobes.
  always_ff @(posedge clk_i) begin
    if (state_q == S_INIT) begin
      mem_q[sweep_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (wstrb_i[k]) begin
          mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^wstrb_i;

  // Storage array: init sweep and request writes both update full words.
  always_ff @(posedge clk_i) begin
    if (state_q == S_INIT) begin
      mem_q[sweep_q] <= '0;
    end else if (wr_en) begin
      mem_q[addr_i] <= wdata_i;
    end
  end
`endif

  // Control FSM with registered handshake and response outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= S_INIT;
      sweep_q      <= '0;
      lat_q        <= '0;
      ready_q      <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        S_INIT: begin
          if (sweep_q == LAST_ADDR) begin
            sweep_q <= '0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end else begin
            sweep_q <= sweep_q + ADDR_WIDTH'(1);
          end
        end
        S_IDLE: begin
          if (accept) begin
            ready_q <= 1'b0;
            rdata_q <= rdata_d;
            err_q   <= addr_err;
            lat_q   <= '0;
            if (RD_LATENCY > 1) begin
              state_q <= S_WAIT;
            end else begin
              resp_valid_q <= 1'b1;
              state_q      <= S_RESP;
            end
          end
        end
        S_WAIT: begin
          if (lat_q == LAT_LAST) begin
            resp_valid_q <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            lat_q <= lat_q + 2'd1;
          end
        end
        S_RESP: begin
          if (resp_ready_i) begin
            resp_valid_q <= 1'b0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            ready_q      <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_INIT;
        end
      endcase
    end
  end

  assign ready_o      = ready_q;
  assign resp_valid_o = resp_valid_q;
  assign rdata_o      = rdata_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_mem_ctrl_v2.sv
// tb_mem_ctrl_v2: directed bench for mem_ctrl_v2 using two instances,
// A (DEPTH=16, RD_LATENCY=1) and B (DEPTH=12, RD_LATENCY=3), which share
// stimulus through a select line. Table-driven transactions plus
// hand-written backpressure and reset-abort sequences.
module tb_mem_ctrl_v2;

`ifdef MEM_BYTE_STROBE_EN
  localparam bit STRB_ON = 1'b1;
`else
  localparam bit STRB_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic        wr_rd = 1'b0;
  logic [3:0]  addr = '0;
  logic [15:0] wdata = '0;
  logic [1:0]  wstrb = '0;
  logic        resp_ready = 1'b1;

  logic        ready_a, ready_b, resp_valid_a, resp_valid_b, err_a, err_b;
  logic [15:0] rdata_a, rdata_b;
  logic        valid_a, valid_b;
  logic        ready, resp_valid, err;
  logic [15:0] rdata;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign valid_a    = valid & ~sel;
  assign valid_b    = valid & sel;
  assign ready      = sel ? ready_b : ready_a;
  assign resp_valid = sel ? resp_valid_b : resp_valid_a;
  assign rdata      = sel ? rdata_b : rdata_a;
  assign err        = sel ? err_b : err_a;

  mem_ctrl_v2 #(.WIDTH(16), .DEPTH(16), .RD_LATENCY(1)) dut_a (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_a), .ready_o(ready_a),
    .wr_rd_i(wr_rd), .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb),
    .resp_valid_o(resp_valid_a), .resp_ready_i(resp_ready),
    .rdata_o(rdata_a), .err_o(err_a)
  );

  mem_ctrl_v2 #(.WIDTH(16), .DEPTH(12), .RD_LATENCY(3)) dut_b (
    .clk_i(clk), .rst_i(rst_n), .valid_i(valid_b), .ready_o(ready_b),
    .wr_rd_i(wr_rd), .addr_i(addr), .wdata_i(wdata), .wstrb_i(wstrb),
    .resp_valid_o(resp_valid_b), .resp_ready_i(resp_ready),
    .rdata_o(rdata_b), .err_o(err_b)
  );

  typedef struct packed {
    bit          use_b;
    bit          wr;
    logic [3:0]  addr;
    logic [15:0] wdata;
    logic [1:0]  strb;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one request on the selected instance; report response and latency.
  task automatic xact(input bit wr, input logic [3:0] a, input logic [15:0] d,
                      input logic [1:0] s, input bit rr,
                      output logic [15:0] rd, output logic er, output int lat);
    int n;
    valid = 1'b1; wr_rd = wr; addr = a; wdata = d; wstrb = s; resp_ready = rr;
    n = 0;
    while (!ready && n < 50) begin
      step();
      n++;
    end
    step();
    valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 20) begin
      step();
      lat++;
    end
    rd = rdata;
    er = err;
    if (rr) step();
  endtask

  // Release reset mid-sequence and measure both init sweep lengths.
  task automatic reset_release(input string tag);
    int na, nb;
    bit rv_seen;
    na = 0; nb = 0; rv_seen = 1'b0;
    valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (ready_a && na == 0) na = c;
      if (ready_b && nb == 0) nb = c;
      if (resp_valid_a || resp_valid_b) rv_seen = 1'b1;
    end
    check({tag, "_init_cycles_a"}, na, 16);
    check({tag, "_init_cycles_b"}, nb, 12);
    check({tag, "_no_resp_after_reset"}, {31'b0, rv_seen}, 0);
  endtask

  initial begin
    logic [15:0] rd;
    logic        er;
    int          lat;

    vecs[0]  = '{1'b0, 1'b0, 4'd5,  16'h0000, 2'b11, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 4'd7,  16'h1357, 2'b11, 16'h0000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 4'd7,  16'h0000, 2'b11, 16'h1357, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 4'd15, 16'hFFFF, 2'b11, 16'h0000, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 4'd15, 16'h0000, 2'b11, 16'hFFFF, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 4'd0,  16'h0000, 2'b11, 16'h0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 4'd3,  16'hBEEF, 2'b11, 16'h0000, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 4'd3,  16'h0000, 2'b11, 16'hBEEF, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 4'd11, 16'h0B0B, 2'b11, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, 4'd13, 16'h1234, 2'b11, 16'h0000, 1'b1};
    vecs[10] = '{1'b1, 1'b0, 4'd13, 16'h0000, 2'b11, 16'h0000, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 4'd11, 16'h0000, 2'b11, 16'h0B0B, 1'b0};
    vecs[12] = '{1'b1, 1'b1, 4'd12, 16'h7777, 2'b11, 16'h0000, 1'b1};
    vecs[13] = '{1'b1, 1'b0, 4'd11, 16'h0000, 2'b11, 16'h0B0B, 1'b0};
    vecs[14] = '{1'b1, 1'b1, 4'd2,  16'hAAAA, 2'b11, 16'h0000, 1'b0};
    vecs[15] = '{1'b1, 1'b1, 4'd2,  16'h5555, 2'b01, 16'h0000, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 4'd2,  16'h0000, 2'b11, STRB_ON ? 16'hAA55 : 16'h5555, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 4'd7,  16'h0000, 2'b00, 16'h0000, 1'b0};
    vecs[18] = '{1'b0, 1'b0, 4'd7,  16'h0000, 2'b11, STRB_ON ? 16'h1357 : 16'h0000, 1'b0};

    // Reset state, asynchronous and before any clock edge.
    #2;
    check("rst_ready_a", {31'b0, ready_a}, 0);
    check("rst_ready_b", {31'b0, ready_b}, 0);
    check("rst_resp_valid_a", {31'b0, resp_valid_a}, 0);
    check("rst_resp_valid_b", {31'b0, resp_valid_b}, 0);
    check("rst_rdata_a", {16'b0, rdata_a}, 0);
    check("rst_err_a", {31'b0, err_a}, 0);
    reset_release("por");

    // Table-driven transactions with resp_ready held high.
    for (int i = 0; i < NV; i++) begin
      sel = vecs[i].use_b;
      xact(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, 1'b1, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), {16'b0, rd}, {16'b0, vecs[i].exp_rdata});
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), lat, vecs[i].use_b ? 3 : 1);
      check($sformatf("vec%0d_ready_after", i), {31'b0, ready}, 1);
    end

    // Backpressure on B; a write offered while stalled must be ignored.
    sel = 1'b1;
    xact(1'b0, 4'd3, 16'h0000, 2'b11, 1'b0, rd, er, lat);
    check("bp_latency", lat, 3);
    valid = 1'b1; wr_rd = 1'b1; addr = 4'd3; wdata = 16'hDEAD; wstrb = 2'b11;
    for (int c = 0; c < 5; c++) begin
      step();
      check($sformatf("bp%0d_resp_valid", c), {31'b0, resp_valid}, 1);
      check($sformatf("bp%0d_rdata", c), {16'b0, rdata}, 32'hBEEF);
      check($sformatf("bp%0d_ready", c), {31'b0, ready}, 0);
    end
    valid = 1'b0;
    resp_ready = 1'b1;
    step();
    check("bp_release_resp_valid", {31'b0, resp_valid}, 0);
    check("bp_release_ready", {31'b0, ready}, 1);
    xact(1'b0, 4'd3, 16'h0000, 2'b11, 1'b1, rd, er, lat);
    check("bp_stall_write_ignored", {16'b0, rd}, 32'hBEEF);

    // Reset while A holds a response under backpressure.
    sel = 1'b0;
    xact(1'b0, 4'd15, 16'h0000, 2'b11, 1'b0, rd, er, lat);
    check("resp_rst_pre_rdata", {16'b0, rd}, 32'hFFFF);
    #3;
    rst_n = 1'b0;
    #1;
    check("resp_rst_resp_valid", {31'b0, resp_valid_a}, 0);
    check("resp_rst_rdata", {16'b0, rdata_a}, 0);
    check("resp_rst_ready", {31'b0, ready_a}, 0);
    resp_ready = 1'b1;
    reset_release("rst1");

    // Reset during WAIT of a read on B.
    sel = 1'b1;
    xact(1'b1, 4'd3, 16'hC0DE, 2'b11, 1'b1, rd, er, lat);
    valid = 1'b1; wr_rd = 1'b0; addr = 4'd3;
    step();
    valid = 1'b0;
    check("wait_rst_pre_resp_valid", {31'b0, resp_valid_b}, 0);
    check("wait_rst_pre_ready", {31'b0, ready_b}, 0);
    step();
    #3;
    rst_n = 1'b0;
    #1;
    check("wait_rst_resp_valid", {31'b0, resp_valid_b}, 0);
    check("wait_rst_ready", {31'b0, ready_b}, 0);
    reset_release("rst2");

    xact(1'b0, 4'd3, 16'h0000, 2'b11, 1'b1, rd, er, lat);
    check("post_rst_b_addr3", {16'b0, rd}, 0);
    check("post_rst_b_latency", lat, 3);
    sel = 1'b0;
    xact(1'b0, 4'd15, 16'h0000, 2'b11, 1'b1, rd, er, lat);
    check("post_rst_a_addr15", {16'b0, rd}, 0);
    check("post_rst_a_err", {31'b0, er}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_v2.md
Name: mem_ctrl_v2

Overview:
Parametrised single-port synchronous memory with separate request and response handshakes. It succeeds the fixed 16x16 valid/ready memory. It adds:
- configurable width, depth and read latency
- response backpressure
- out-of-range error reporting
- a post-reset zero-initialisation sweep

It sits behind a bus master as a generic scratch RAM slave.

Parameters:
- WIDTH, 16, data word width in bits (multiple of 8)
- DEPTH, 16, number of words (need not be a power of 2)
- ADDR_WIDTH, $clog2(DEPTH) (minimum 1), address bus width
- RD_LATENCY, 1, cycles from request acceptance to response valid (legal range 1..4)

Ports:
- clk_i  in  1  clock; all state updates on rising edge
- rst_i  in  1  reset; asynchronous assert, active-low (0 = reset)
- valid_i  in  1  request valid
- ready_o  out  1  request ready; a transfer occurs when valid_i & ready_o
- wr_rd_i  in  1  1 = write, 0 = read
- addr_i  in  ADDR_WIDTH  word address
- wdata_i  in  WIDTH  write data
- wstrb_i  in  WIDTH/8  byte write strobes (used only when MEM_BYTE_STROBE_EN is defined)
- resp_valid_o  out  1  response valid
- resp_ready_i  in  1  response accepted when resp_valid_o & resp_ready_i
- rdata_o  out  WIDTH  read data; 0 for write and error responses
- err_o  out  1  response carries error (addr_i >= DEPTH)

Behaviour:
- Reset (rst_i=0, asynchronous): ready_o=0, resp_valid_o=0, rdata_o=0, err_o=0, counters cleared, FSM=INIT.
  - Assertion mid-transaction aborts it; a pending response is dropped.
- FSM states: INIT, IDLE, WAIT, RESP.
- INIT:
  - A sweep counter writes 0 to mem[0..DEPTH-1], one word per cycle, for exactly DEPTH cycles after reset release.
  - ready_o=0 throughout; then go to IDLE.
- IDLE:
  - ready_o=1.
  - On handshake, capture wr_rd_i, addr_i and the error flag (addr_i >= DEPTH).
  - Write, no error: update mem[addr_i] on the accept edge.
  - Read, no error: sample mem[addr_i] on the accept edge.
  - Error requests never modify memory.
  - Next state: WAIT if RD_LATENCY>1, else RESP.
- WAIT:
  - ready_o=0.
  - A latency counter counts RD_LATENCY-1 cycles, then go to RESP.
- RESP:
  - resp_valid_o=1 with rdata_o and err_o stable until resp_ready_i=1.
  - On handshake: resp_valid_o=0 next cycle and return to IDLE.
  - ready_o=0 while in RESP; one outstanding transaction max.
- Latency:
  - resp_valid_o rises exactly RD_LATENCY cycles after the accept edge.
  - Minimum request-to-request spacing is RD_LATENCY+1 cycles with resp_ready_i held 1.
- Writes also return a response: rdata_o=0, err_o = out-of-range flag.
- Read-after-write to the same address in consecutive transactions returns the new data.
- The read value is the memory content at the accept edge; memory cannot change during WAIT/RESP.
- Any valid_i or addr_i changes while ready_o=0 are ignored.
- X on valid_i is not tolerated; the bench must drive 0 when idle.

Optional Feature:
Macro MEM_BYTE_STROBE_EN.
- Defined: a write updates only the bytes whose wstrb_i bit is 1 (bit k covers wdata_i[8k+7:8k]). wstrb_i=0 leaves the word unchanged but still returns a normal response.
- Undefined: wstrb_i is ignored and every write updates the full word.
- The init sweep always writes full words in both builds.

Test Plan:
1. Reset release, DEPTH=16 → ready_o=0 for 16 cycles, then 1; an immediate read of addr 5 returns rdata_o=0x0000, err_o=0.
2. RD_LATENCY=3: write 0xBEEF to addr 3, then read addr 3 with resp_ready_i=1 → read resp_valid_o rises exactly 3 cycles after accept, rdata_o=0xBEEF.
3. Backpressure: read addr 3 with resp_ready_i=0 for 5 cycles → resp_valid_o and rdata_o=0xBEEF held stable, ready_o=0; raise resp_ready_i → resp_valid_o falls next cycle, ready_o=1.
4. DEPTH=12: write 0x1234 to addr 13, then read addr 13 → both responses err_o=1, rdata_o=0; a read of addr 11 still returns its prior value.
5. MEM_BYTE_STROBE_EN defined: addr 2 holds 0xAAAA; write 0x5555 with wstrb_i=2'b01 → read gives 0xAA55. Undefined: same stimulus gives 0x5555.
6. rst_i pulsed low during WAIT of a read → resp_valid_o=0 immediately; after release the sweep reruns and addr 3 reads 0x0000.
